// File: rtl/semi_auto_pkg.sv
// rtl/semi_auto_pkg.sv - state encodings and motion codes for the semi-auto sequencer
package semi_auto_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CRUISE    = 3'd1,
    S_WAIT      = 3'd2,
    S_TURN_L    = 3'd3,
    S_TURN_R    = 3'd4,
    S_TURN_BACK = 3'd5,
    S_EXIT      = 3'd6
  } seq_state_e;

  localparam logic [3:0] MV_STOP  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  // Turn-around is executed as a double left turn in place.
  function automatic logic [3:0] mv_for(input seq_state_e s);
    case (s)
      S_CRUISE, S_EXIT:      mv_for = MV_FWD;
      S_TURN_L, S_TURN_BACK: mv_for = MV_LEFT;
      S_TURN_R:              mv_for = MV_RIGHT;
      default:               mv_for = MV_STOP;
    endcase
  endfunction

endpackage

// File: rtl/semi_auto_sequencer_det_settle.sv
// rtl/semi_auto_sequencer_det_settle.sv - 3-bit detector stability filter with new-pattern strobe
module det_settle #(
  parameter int SETTLE_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [2:0] raw,
  output logic [2:0] settled,
  output logic       strobe
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(SETTLE_CYCLES);

  logic [2:0]    last_raw;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          restart;
  logic          fire;

  // cnt is the length of the current run of identical samples, saturating at C_MAX.
  always_comb begin
    restart  = clear || (raw != last_raw);
    cnt_next = restart ? CW'(1) : ((cnt == C_MAX) ? cnt : cnt + 1'b1);
    fire     = (cnt_next == C_MAX) && (restart || (cnt != C_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_raw <= 3'b000;
      cnt      <= '0;
      settled  <= 3'b000;
      strobe   <= 1'b0;
    end else begin
      last_raw <= raw;
      cnt      <= cnt_next;
      strobe   <= fire;
      if (fire) settled <= raw;
    end
  end

endmodule

// File: rtl/semi_auto_sequencer.sv
// rtl/semi_auto_sequencer.sv - semi-auto drive sequencer producing the moving_state nibble
module semi_auto_sequencer
  import semi_auto_pkg::*;
#(
  parameter int TURN_CYCLES   = 90_000_000,
  parameter int EXIT_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       det_back,
  input  logic       cmd_fwd,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_back,
  output logic [3:0] moving_state,
  output logic [2:0] seq_state,
  output logic       waiting
);

  localparam int TW = $clog2(2 * TURN_CYCLES + 1);
  localparam logic [TW-1:0] T_TURN = TW'(TURN_CYCLES);
  localparam logic [TW-1:0] T_BACK = TW'(2 * TURN_CYCLES);
  localparam logic [TW-1:0] T_EXIT = TW'(EXIT_CYCLES);

  seq_state_e    state;
  seq_state_e    next_state;
  logic [TW-1:0] timer;
  logic [3:0]    cmd_now;
  logic [3:0]    cmd_prev;
  logic [3:0]    cmd_rise;
  logic [2:0]    pat;
  logic          pat_new;
  logic          settle_clear;
  logic          unused_det_back;

  assign unused_det_back = det_back;
  assign cmd_now   = {cmd_fwd, cmd_left, cmd_right, cmd_back};
  assign cmd_rise  = cmd_now & ~cmd_prev;
  assign seq_state = state;

  // Restart the filter while parked and on every re-entry to CRUISE.
  assign settle_clear = !enable || (state == S_IDLE) || ((state == S_EXIT) && (timer == TW'(1)));

  det_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clear  (settle_clear),
    .raw    ({det_front, det_left, det_right}),
    .settled(pat),
    .strobe (pat_new)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = S_CRUISE;
      S_CRUISE: begin
        if (pat_new) begin
          case (pat)
            3'b111:  next_state = S_TURN_BACK;
            3'b110:  next_state = S_TURN_R;
            3'b101:  next_state = S_TURN_L;
            3'b011:  next_state = S_CRUISE;
            default: next_state = S_WAIT;
          endcase
        end
      end
      // Only the highest-priority edge is considered; if its target is blocked it is dropped.
      S_WAIT: begin
        if (cmd_rise[3]) begin
          if (!pat[2]) next_state = S_EXIT;
        end else if (cmd_rise[2]) begin
          if (!pat[1]) next_state = S_TURN_L;
        end else if (cmd_rise[1]) begin
          if (!pat[0]) next_state = S_TURN_R;
        end else if (cmd_rise[0]) begin
          next_state = S_TURN_BACK;
        end
      end
      S_TURN_L, S_TURN_R, S_TURN_BACK: if (timer == TW'(1)) next_state = S_EXIT;
      S_EXIT:  if (timer == TW'(1)) next_state = S_CRUISE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      moving_state <= MV_STOP;
      waiting      <= 1'b0;
      timer        <= '0;
      cmd_prev     <= 4'b0000;
    end else if (!enable) begin
      state        <= S_IDLE;
      moving_state <= MV_STOP;
      waiting      <= 1'b0;
      timer        <= '0;
      cmd_prev     <= 4'b0000;
    end else begin
      state        <= next_state;
      moving_state <= mv_for(next_state);
      waiting      <= (next_state == S_WAIT);
      cmd_prev     <= cmd_now;
      if (next_state != state) begin
        case (next_state)
          S_TURN_L, S_TURN_R: timer <= T_TURN;
          S_TURN_BACK:        timer <= T_BACK;
          S_EXIT:             timer <= T_EXIT;
          default:            timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

endmodule

// File: doc/semi_auto_sequencer.md
Name: semi_auto_sequencer

Overview:
- Semi-auto drive controller: sequences the car's moving_state nibble (the low 4 bits of the UART command byte {2'b10, destroy, place, moving_state}) from the four detector bits returned by the simulator and from the user's direction buttons.
- Cruises forward until a junction or obstacle is seen, then resolves it: auto-turns in corridors and dead ends, otherwise waits for the user to choose.
- Sits beside the manual controller; the top-level muxes its moving_state onto the UART byte when semi-auto mode is selected.

Parameters:
- TURN_CYCLES, 90_000_000, clk cycles of turn-in-place for a 90 degree turn.
- EXIT_CYCLES, 50_000_000, forced-forward cycles after a turn or a forward choice, with detectors ignored, to clear the junction.
- SETTLE_CYCLES, 10_000_000, cycles a detector pattern must hold unchanged before it is acted on.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- enable  in  1  semi-auto mode selected and power on (level)
- det_front  in  1  1 = obstacle ahead
- det_left  in  1  1 = obstacle left
- det_right  in  1  1 = obstacle right
- det_back  in  1  1 = obstacle behind (status only; not used for decisions)
- cmd_fwd  in  1  user forward button (level; rising edge used)
- cmd_left  in  1  user left button (level; rising edge used)
- cmd_right  in  1  user right button (level; rising edge used)
- cmd_back  in  1  user turn-around button (level; rising edge used)
- moving_state  out  4  registered motion code; bit0 fwd, bit1 back, bit2 turn-left, bit3 turn-right
- seq_state  out  3  current FSM state, for the state LEDs
- waiting  out  1  high in WAIT (user decision required)

Behaviour:
- Reset, and whenever enable=0: state IDLE, moving_state=4'b0000, waiting=0, timers and edge detectors cleared. Takes effect next edge, including mid-turn or mid-exit.
- All outputs are registered and are a pure function of the state:
  - IDLE: 0000
  - CRUISE: 0001
  - WAIT: 0000
  - TURN_L: 0100
  - TURN_R: 1000
  - TURN_BACK: 0100
  - EXIT: 0001
- Settled pattern P = {front, left, right}: updates only after the raw pattern has been identical for SETTLE_CYCLES consecutive cycles. Any change restarts the settle count.
- IDLE -> CRUISE: one cycle after enable=1.
- CRUISE, settled P = {1, 1, 1} (dead end): -> TURN_BACK.
- CRUISE, settled P = {1, x, x} with exactly one side open: auto -> TURN_L or TURN_R.
- CRUISE, settled P = {0, 1, 1}: stay in CRUISE.
- CRUISE, any other settled P (a side open with front open, or front blocked with both sides open): -> WAIT.
- WAIT, edge priority when several arrive in the same cycle: fwd > left > right > back.
  - Accepted only if the target is open: fwd needs front=0, left needs left=0, right needs right=0. Back is always accepted.
  - fwd -> EXIT; left -> TURN_L; right -> TURN_R; back -> TURN_BACK.
  - A rejected command is dropped, not queued.
  - Edges that occur outside WAIT are ignored.
- TURN_L / TURN_R: last exactly TURN_CYCLES cycles, then -> EXIT.
- TURN_BACK: lasts 2*TURN_CYCLES cycles, then -> EXIT.
- EXIT: lasts exactly EXIT_CYCLES cycles, then -> CRUISE. On entry to CRUISE the settle filter restarts.
- Timer: one down-counter, width $clog2(2*TURN_CYCLES+1). Loaded on state entry; the state exits in the cycle it reaches 1. No wrap.

Decomposition:
- Shared package semi_auto_pkg:
  - state encodings: IDLE=0, CRUISE=1, WAIT=2, TURN_L=3, TURN_R=4, TURN_BACK=5, EXIT=6
  - moving_state codes: MV_STOP, MV_FWD, MV_LEFT, MV_RIGHT
- One sub-module, det_settle: a 3-bit stability filter (SETTLE_CYCLES parameter, async rst) that outputs the settled pattern and a one-cycle "new pattern" strobe.

Test Plan (TURN_CYCLES=8, EXIT_CYCLES=5, SETTLE_CYCLES=3):
- Reset, enable=1, P={0,1,1} -> moving_state 0000 during reset; 0001 and seq_state=1 one cycle after enable, held indefinitely.
- CRUISE, det_left=0 for 3 cycles -> WAIT, 0000, waiting=1. Then a cmd_left pulse -> 0100 for 8 cycles, 0001 for 5 cycles, then CRUISE.
- CRUISE, det_left=0 for only 2 cycles then back to 1 -> remains CRUISE, 0001 throughout.
- CRUISE, P={1,1,0} settled -> TURN_R (1000) with no command. P={1,1,1} -> TURN_BACK, 0100 for 16 cycles, then EXIT.
- WAIT with P={0,0,1}: cmd_fwd and cmd_left rise in the same cycle -> EXIT (fwd wins). Separately, cmd_right -> ignored, stays WAIT.
- enable dropped on cycle 4 of TURN_L -> IDLE and 0000 next cycle. Async rst asserted mid-EXIT -> 0000 immediately, without waiting for a clock edge.
